// File: rtl/pdp_mem_arbiter.sv
// PDP-8 main memory arbiter: IFU fetch, EXEC read and EXEC write
// share one registered-read memory port, one operation at a time.
module pdp_mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 12,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic                  ifu_rd_gnt,
  output logic                  ifu_rd_vld,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic                  exec_rd_gnt,
  output logic                  exec_rd_vld,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_gnt,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SRC_IFU, SRC_RD, SRC_WR} src_t;

  state_t                state;
  src_t                  src;
  src_t                  win;
  logic [3:0]            starve_cnt;
  logic [2:0]            wait_cnt;
  logic                  any_req;
  logic                  ifu_win;
  logic [ADDR_WIDTH-1:0] win_addr;

  assign any_req = ifu_rd_req | exec_rd_req | exec_wr_req;

  // A starved IFU overrides both EXEC requesters
  assign ifu_win = ifu_rd_req &
                   ((starve_cnt == 4'(STARVE_LIMIT)) |
                    ~(exec_rd_req | exec_wr_req));

  always_comb begin
    win      = SRC_IFU;
    win_addr = ifu_rd_addr;
    if (ifu_win) begin
      win      = SRC_IFU;
      win_addr = ifu_rd_addr;
    end else if (exec_wr_req) begin
      win      = SRC_WR;
      win_addr = exec_wr_addr;
    end else if (exec_rd_req) begin
      win      = SRC_RD;
      win_addr = exec_rd_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      src          <= SRC_IFU;
      starve_cnt   <= '0;
      wait_cnt     <= '0;
      ifu_rd_gnt   <= 1'b0;
      exec_rd_gnt  <= 1'b0;
      exec_wr_gnt  <= 1'b0;
      ifu_rd_vld   <= 1'b0;
      exec_rd_vld  <= 1'b0;
      ifu_rd_data  <= '0;
      exec_rd_data <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      ifu_rd_gnt  <= 1'b0;
      exec_rd_gnt <= 1'b0;
      exec_wr_gnt <= 1'b0;
      ifu_rd_vld  <= 1'b0;
      exec_rd_vld <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state       <= ISSUE;
            src         <= win;
            mem_req     <= 1'b1;
            mem_we      <= (win == SRC_WR);
            mem_addr    <= win_addr;
            ifu_rd_gnt  <= (win == SRC_IFU);
            exec_rd_gnt <= (win == SRC_RD);
            exec_wr_gnt <= (win == SRC_WR);
            if (win == SRC_WR)
              mem_wdata <= exec_wr_data;
            if (ifu_rd_req) begin
              if (ifu_win)
                starve_cnt <= '0;
              else if (starve_cnt != 4'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= (src == SRC_WR) ? IDLE : WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'(RD_LATENCY - 1)) begin
            state <= RESP;
            if (src == SRC_IFU) begin
              ifu_rd_data <= mem_rdata;
              ifu_rd_vld  <= 1'b1;
            end else begin
              exec_rd_data <= mem_rdata;
              exec_rd_vld  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Requesters must hold req until their grant
  a_ifu_hold: assert property (@(posedge clk) disable iff (reset)
    ifu_rd_req && !ifu_rd_gnt |=> ifu_rd_req);
  a_rd_hold: assert property (@(posedge clk) disable iff (reset)
    exec_rd_req && !exec_rd_gnt |=> exec_rd_req);
  a_wr_hold: assert property (@(posedge clk) disable iff (reset)
    exec_wr_req && !exec_wr_gnt |=> exec_wr_req);
  a_gnt_1h: assert property (@(posedge clk) disable iff (reset)
    $onehot0({ifu_rd_gnt, exec_rd_gnt, exec_wr_gnt}));

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Bench for pdp_mem_arbiter: queued requesters, a latency-arithmetic
// reference model, and a second instance built with RD_LATENCY=3.
module tb_pdp_mem_arbiter;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int LIM  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        ifu_rd_req, ifu_rd_gnt, ifu_rd_vld;
  logic [11:0] ifu_rd_addr, ifu_rd_data;
  logic        exec_rd_req, exec_rd_gnt, exec_rd_vld;
  logic [11:0] exec_rd_addr, exec_rd_data;
  logic        exec_wr_req, exec_wr_gnt;
  logic [11:0] exec_wr_addr, exec_wr_data;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr, mem_wdata, mem_rdata;

  logic        d3_ifu_rd_req, d3_ifu_rd_gnt, d3_ifu_rd_vld;
  logic [11:0] d3_ifu_rd_addr, d3_ifu_rd_data;
  logic        d3_exec_rd_req, d3_exec_rd_gnt, d3_exec_rd_vld;
  logic [11:0] d3_exec_rd_addr, d3_exec_rd_data;
  logic        d3_exec_wr_req, d3_exec_wr_gnt;
  logic [11:0] d3_exec_wr_addr, d3_exec_wr_data;
  logic        d3_mem_req, d3_mem_we;
  logic [11:0] d3_mem_addr, d3_mem_wdata, d3_mem_rdata;

  pdp_mem_arbiter #(.RD_LATENCY(LAT), .STARVE_LIMIT(LIM)) u_dut (
    .clk(clk), .reset(reset),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_gnt(ifu_rd_gnt), .ifu_rd_vld(ifu_rd_vld),
    .ifu_rd_data(ifu_rd_data),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
    .exec_rd_gnt(exec_rd_gnt), .exec_rd_vld(exec_rd_vld),
    .exec_rd_data(exec_rd_data),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr),
    .exec_wr_data(exec_wr_data), .exec_wr_gnt(exec_wr_gnt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  pdp_mem_arbiter #(.RD_LATENCY(LAT3), .STARVE_LIMIT(LIM)) u_dut3 (
    .clk(clk), .reset(reset),
    .ifu_rd_req(d3_ifu_rd_req), .ifu_rd_addr(d3_ifu_rd_addr),
    .ifu_rd_gnt(d3_ifu_rd_gnt), .ifu_rd_vld(d3_ifu_rd_vld),
    .ifu_rd_data(d3_ifu_rd_data),
    .exec_rd_req(d3_exec_rd_req), .exec_rd_addr(d3_exec_rd_addr),
    .exec_rd_gnt(d3_exec_rd_gnt), .exec_rd_vld(d3_exec_rd_vld),
    .exec_rd_data(d3_exec_rd_data),
    .exec_wr_req(d3_exec_wr_req), .exec_wr_addr(d3_exec_wr_addr),
    .exec_wr_data(d3_exec_wr_data), .exec_wr_gnt(d3_exec_wr_gnt),
    .mem_req(d3_mem_req), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
    .mem_wdata(d3_mem_wdata), .mem_rdata(d3_mem_rdata));

  function automatic logic [11:0] init_val(input logic [11:0] a);
    if (a == 12'o0200) return 12'o7402;
    if (a == 12'o4000) return 12'o0017;
    return 12'(a * 12'd37 + 12'd5);
  endfunction

  // Memory: registered read, junk on the read bus when no read is due
  logic [11:0] mem [4096];
  bit          wr_bit [4096];
  logic [11:0] pipe [LAT];
  logic [11:0] pipe3 [LAT3];

  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      mem[mem_addr]    <= mem_wdata;
      wr_bit[mem_addr] <= 1'b1;
    end
    if (mem_req && !mem_we)
      pipe[0] <= wr_bit[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    else
      pipe[0] <= 12'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (d3_mem_req && !d3_mem_we)
      pipe3[0] <= init_val(d3_mem_addr);
    else
      pipe3[0] <= 12'($urandom);
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign mem_rdata    = pipe[LAT-1];
  assign d3_mem_rdata = pipe3[LAT3-1];

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester queues; req is held while its queue is non-empty
  logic [11:0] q_ifu[$];
  logic [11:0] q_rd[$];
  logic [23:0] q_wr[$];
  logic f_ifu = 1'b0;
  logic f_rd = 1'b0;
  logic f_wr = 1'b0;

  initial begin
    ifu_rd_req = 0; ifu_rd_addr = 0;
    exec_rd_req = 0; exec_rd_addr = 0;
    exec_wr_req = 0; exec_wr_addr = 0; exec_wr_data = 0;
    forever begin
      @(posedge clk);
      #3;
      if (f_ifu && q_ifu.size() > 0) void'(q_ifu.pop_front());
      if (f_rd && q_rd.size() > 0) void'(q_rd.pop_front());
      if (f_wr && q_wr.size() > 0) void'(q_wr.pop_front());
      ifu_rd_req   = q_ifu.size() > 0;
      ifu_rd_addr  = ifu_rd_req ? q_ifu[0] : 12'd0;
      exec_rd_req  = q_rd.size() > 0;
      exec_rd_addr = exec_rd_req ? q_rd[0] : 12'd0;
      exec_wr_req  = q_wr.size() > 0;
      exec_wr_addr = exec_wr_req ? q_wr[0][23:12] : 12'd0;
      exec_wr_data = exec_wr_req ? q_wr[0][11:0] : 12'd0;
    end
  end

  // Reference model: per-cycle expectations keyed by cycle number
  int          exp_gnt[int];
  logic [11:0] exp_addr[int];
  logic [11:0] exp_wd[int];
  int          exp_vld[int];
  logic [11:0] exp_vdata[int];
  logic [11:0] ref_mem[int];
  logic [11:0] m_ifu_data = 0;
  logic [11:0] m_exec_data = 0;
  int          starve = 0;
  int          free_cyc = 0;

  int          dut_log[$];
  logic [11:0] ifu_gaddr[$];
  logic [11:0] ifu_vdata[$];
  int          gnt_cyc[3];
  int          vld_cyc[2];
  int          n_exec_vld = 0;
  int          n_multi = 0;

  function automatic logic [11:0] ref_val(input logic [11:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  initial forever begin : mon
    int g, v, w;
    logic [11:0] a;
    @(negedge clk);
    if (reset) begin
      exp_gnt.delete(); exp_addr.delete(); exp_wd.delete();
      exp_vld.delete(); exp_vdata.delete();
      m_ifu_data = 0; m_exec_data = 0; starve = 0;
      free_cyc = cyc + 1;
      f_ifu = 0; f_rd = 0; f_wr = 0;
    end else begin
      f_ifu = ifu_rd_gnt; f_rd = exec_rd_gnt; f_wr = exec_wr_gnt;
      if ($countones({ifu_rd_gnt, exec_rd_gnt, exec_wr_gnt}) > 1) n_multi++;
      if (ifu_rd_gnt) begin
        dut_log.push_back(0); gnt_cyc[0] = cyc; ifu_gaddr.push_back(mem_addr);
      end
      if (exec_rd_gnt) begin dut_log.push_back(1); gnt_cyc[1] = cyc; end
      if (exec_wr_gnt) begin dut_log.push_back(2); gnt_cyc[2] = cyc; end
      if (ifu_rd_vld) begin vld_cyc[0] = cyc; ifu_vdata.push_back(ifu_rd_data); end
      if (exec_rd_vld) begin vld_cyc[1] = cyc; n_exec_vld++; end

      g = exp_gnt.exists(cyc) ? exp_gnt[cyc] : -1;
      chk("gnt", {exec_wr_gnt, exec_rd_gnt, ifu_rd_gnt}, {g == 2, g == 1, g == 0});
      chk("mem_req", mem_req, g >= 0);
      if (g >= 0) begin
        chk("mem_we", mem_we, g == 2);
        chk("mem_addr", mem_addr, exp_addr[cyc]);
        if (g == 2) chk("mem_wdata", mem_wdata, exp_wd[cyc]);
      end
      v = exp_vld.exists(cyc) ? exp_vld[cyc] : -1;
      if (v == 0) m_ifu_data = exp_vdata[cyc];
      if (v == 1) m_exec_data = exp_vdata[cyc];
      chk("vld", {exec_rd_vld, ifu_rd_vld}, {v == 1, v == 0});
      chk("ifu_rd_data", ifu_rd_data, m_ifu_data);
      chk("exec_rd_data", exec_rd_data, m_exec_data);
      exp_gnt.delete(cyc); exp_vld.delete(cyc);

      if (cyc == free_cyc) begin
        if (!(ifu_rd_req || exec_rd_req || exec_wr_req)) begin
          free_cyc = cyc + 1;
        end else begin
          if (ifu_rd_req && (starve == LIM || !(exec_rd_req || exec_wr_req))) begin
            w = 0; a = ifu_rd_addr; starve = 0;
          end else begin
            if (ifu_rd_req && starve < LIM) starve++;
            if (exec_wr_req) begin w = 2; a = exec_wr_addr; end
            else begin w = 1; a = exec_rd_addr; end
          end
          exp_gnt[cyc+1] = w;
          exp_addr[cyc+1] = a;
          if (w == 2) begin
            exp_wd[cyc+1] = exec_wr_data;
            ref_mem[int'(a)] = exec_wr_data;
            free_cyc = cyc + 2;
          end else begin
            exp_vld[cyc+2+LAT] = w;
            exp_vdata[cyc+2+LAT] = ref_val(a);
            free_cyc = cyc + 3 + LAT;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (!(q_ifu.size() == 0 && q_rd.size() == 0 && q_wr.size() == 0 &&
             cyc >= free_cyc) && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk({name, "_idle"}, k < budget, 1);
    if (k >= budget) begin
      q_ifu.delete(); q_rd.delete(); q_wr.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, {ifu_rd_gnt, exec_rd_gnt, exec_wr_gnt}, 0);
    chk({tag, "_vld"}, {ifu_rd_vld, exec_rd_vld}, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_ifu_data"}, ifu_rd_data, 0);
    chk({tag, "_exec_data"}, exec_rd_data, 0);
  endtask

  int exp4[10] = '{2, 2, 2, 2, 0, 2, 2, 2, 2, 0};

  initial begin
    int t, nv, g3, v3, n3g, n3m;
    logic [11:0] d3v;
    d3_ifu_rd_req = 0; d3_ifu_rd_addr = 0;
    d3_exec_rd_req = 0; d3_exec_rd_addr = 0;
    d3_exec_wr_req = 0; d3_exec_wr_addr = 0; d3_exec_wr_data = 0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    chk("reset_d3", {d3_mem_req, d3_exec_rd_gnt, d3_exec_rd_vld}, 0);
    reset = 1'b0;

    // RD_LATENCY=3 instance: single EXEC read of 0o4000
    @(posedge clk); #2;
    d3_exec_rd_addr = 12'o4000; d3_exec_rd_req = 1; t = cyc;
    g3 = -1; v3 = -1; n3g = 0; n3m = 0; d3v = 0;
    for (int k = 0; k < 20 && v3 < 0; k++) begin
      @(negedge clk);
      n3g += $countones({d3_ifu_rd_gnt, d3_exec_rd_gnt, d3_exec_wr_gnt});
      if (d3_exec_rd_gnt) g3 = cyc;
      if (d3_mem_req) n3m++;
      if (d3_exec_rd_vld) begin v3 = cyc; d3v = d3_exec_rd_data; end
      @(posedge clk); #2;
      if (g3 >= 0) d3_exec_rd_req = 0;
    end
    d3_exec_rd_req = 0;
    chk("t5_gnt_lat", g3 - t, 1);
    chk("t5_vld_lat", v3 - t, 5);
    chk("t5_data", d3v, 12'o0017);
    chk("t5_gnt_count", n3g, 1);
    chk("t5_memreq_count", n3m, 1);

    // Single IFU read of 0o0200
    gnt_cyc[0] = -1; vld_cyc[0] = -1; ifu_gaddr.delete();
    q_ifu.push_back(12'o0200); t = cyc;
    wait_idle(50, "t2");
    chk("t2_gnt_lat", gnt_cyc[0] - t, 1);
    chk("t2_vld_lat", vld_cyc[0] - t, 3);
    chk("t2_gnt_addr", ifu_gaddr.size() > 0 ? ifu_gaddr[0] : 12'd0, 12'o0200);
    repeat (3) @(posedge clk);
    #2;
    chk("t2_data_hold", ifu_rd_data, 12'o7402);

    // Reset in the WAIT cycle of an EXEC read
    q_rd.push_back(12'o0300);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("t1");
    nv = n_exec_vld;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    q_ifu.push_back(12'o0200);
    wait_idle(50, "t1");
    repeat (4) @(posedge clk);
    #2;
    chk("t1_no_exec_vld", n_exec_vld - nv, 0);
    chk("t1_ifu_data", ifu_rd_data, 12'o7402);

    // Write and read of the same address in one cycle
    gnt_cyc[1] = -1; gnt_cyc[2] = -1;
    q_wr.push_back({12'o0050, 12'o1234});
    q_rd.push_back(12'o0050);
    t = cyc;
    wait_idle(50, "t3");
    chk("t3_wr_gnt_lat", gnt_cyc[2] - t, 1);
    chk("t3_rd_gnt_lat", gnt_cyc[1] - t, 3);
    chk("t3_rd_data", exec_rd_data, 12'o1234);

    // All three held: IFU must win every fifth arbitration
    dut_log.delete();
    for (int i = 0; i < 8; i++) begin
      q_wr.push_back({12'(12'o0100 + i), 12'(i + 1)});
      q_rd.push_back(12'(12'o0100 + i));
    end
    q_ifu.push_back(12'o0010);
    q_ifu.push_back(12'o0011);
    wait_idle(300, "t4");
    for (int i = 0; i < 10; i++)
      chk($sformatf("t4_order%0d", i),
          i < dut_log.size() ? dut_log[i] : -1, exp4[i]);
    chk("t4_multi_gnt", n_multi, 0);

    // Back-to-back IFU reads 0..7
    ifu_gaddr.delete(); ifu_vdata.delete();
    for (int i = 0; i < 8; i++) q_ifu.push_back(12'(i));
    wait_idle(200, "t6");
    chk("t6_gnt_count", ifu_gaddr.size(), 8);
    chk("t6_vld_count", ifu_vdata.size(), 8);
    for (int i = 0; i < 8 && i < ifu_vdata.size() && i < ifu_gaddr.size(); i++) begin
      chk($sformatf("t6_addr%0d", i), ifu_gaddr[i], 12'(i));
      chk($sformatf("t6_data%0d", i), ifu_vdata[i], init_val(12'(i)));
    end

    // Random traffic on a small address window
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #2;
      if (q_ifu.size() < 3 && $urandom_range(0, 2) == 0)
        q_ifu.push_back(12'($urandom_range(0, 15)));
      if (q_rd.size() < 3 && $urandom_range(0, 3) == 0)
        q_rd.push_back(12'($urandom_range(0, 15)));
      if (q_wr.size() < 3 && $urandom_range(0, 3) == 0)
        q_wr.push_back({12'($urandom_range(0, 15)), 12'($urandom)});
    end
    wait_idle(3000, "rand");
    chk("rand_multi_gnt", n_multi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pdp_mem_arbiter.md
Name: pdp_mem_arbiter

Overview:
Shares the single-port PDP-8 main memory (4096 x 12) between three requesters: IFU instruction fetch read, EXEC operand read and EXEC operand write. It runs one memory operation at a time. Selection is fixed-priority, with a starvation guard for the IFU. Requesters talk to the arbiter through req/gnt/vld handshakes. The arbiter drives a registered-read memory port with one request strobe.

Parameters:
ADDR_WIDTH, 12, memory address width (`ADDR_WIDTH)
DATA_WIDTH, 12, memory word width (`DATA_WIDTH)
RD_LATENCY, 1, cycles from mem_req (read) until mem_rdata is valid; legal range 1..4
STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending IFU read wins; legal range 1..15

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
ifu_rd_req  input  1  IFU read request; held until ifu_rd_gnt
ifu_rd_addr  input  ADDR_WIDTH  IFU read address; stable while req is high
ifu_rd_gnt  output  1  one-cycle pulse: IFU request accepted and issued
ifu_rd_vld  output  1  one-cycle pulse: ifu_rd_data valid
ifu_rd_data  output  DATA_WIDTH  IFU read data, held until the next ifu_rd_vld
exec_rd_req  input  1  EXEC read request; held until exec_rd_gnt
exec_rd_addr  input  ADDR_WIDTH  EXEC read address
exec_rd_gnt  output  1  one-cycle pulse: EXEC read issued
exec_rd_vld  output  1  one-cycle pulse: exec_rd_data valid
exec_rd_data  output  DATA_WIDTH  EXEC read data, held until the next exec_rd_vld
exec_wr_req  input  1  EXEC write request; held until exec_wr_gnt
exec_wr_addr  input  ADDR_WIDTH  write address
exec_wr_data  input  DATA_WIDTH  write data
exec_wr_gnt  output  1  one-cycle pulse: write performed this cycle
mem_req  output  1  memory access strobe, one cycle per operation
mem_we  output  1  1 = write, 0 = read; qualified by mem_req
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after a read mem_req

Behaviour:
- Reset state: FSM in IDLE. All gnt, vld, mem_req and mem_we outputs are 0. mem_addr, mem_wdata, ifu_rd_data and exec_rd_data are 0. The starvation counter and the wait counter are 0.
- FSM states:
  - IDLE: if any req is high, register the winner's id, address and data, then go to ISSUE. With no req, stay in IDLE.
  - ISSUE: mem_req=1 and the winner's gnt=1 for exactly this cycle. mem_we=1 for a write, 0 for a read. A write goes to IDLE next; a read goes to WAIT.
  - WAIT: count RD_LATENCY cycles. On the edge ending the last WAIT cycle, capture mem_rdata into the winner's data register, then go to RESP.
  - RESP: the winner's vld=1 for one cycle, then go to IDLE.
- Latency:
  - Write: req seen in cycle t, gnt/mem_req in t+1, next arbitration in t+2.
  - Read: gnt in t+1, vld in t+2+RD_LATENCY. With RD_LATENCY=1 that is t+3.
- Priority is exec_wr > exec_rd > ifu_rd. When starve_cnt == STARVE_LIMIT and ifu_rd_req is high, IFU wins over both EXEC requests.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, at each IDLE arbitration where ifu_rd_req=1 and IFU loses.
  - Clears when IFU is granted.
  - Unchanged when ifu_rd_req=0.
- Simultaneous exec_wr and exec_rd to the same address: the write is served first, so the read returns the new data (read-after-write ordering).
- Requests are sampled only in IDLE. A req that drops before its gnt is a protocol violation: an assertion fires, and the behaviour is undefined.
- gnt signals are mutually exclusive, and so are vld signals. Exactly one operation is outstanding at a time.
- Reset asserted mid-operation: every state returns to IDLE at once. An in-flight read never produces vld, and its data is discarded. A write whose ISSUE cycle has already occurred counts as complete.
- Address and data are fixed by the ISSUE registers; requester changes after gnt have no effect.

Test Plan:
1. Assert reset mid-WAIT of an exec read -> all outputs 0 immediately. After reset releases, no exec_rd_vld appears, and a new ifu_rd_req to 0o0200 completes normally.
2. Single IFU read of 0o0200 (mem holds 0o7402), RD_LATENCY=1 -> ifu_rd_gnt at t+1 with mem_addr=0o0200 and mem_we=0. Then ifu_rd_vld at t+3 with ifu_rd_data=0o7402, and the data holds afterwards.
3. exec_wr (addr 0o0050, data 0o1234) and exec_rd (0o0050) asserted in the same cycle -> write granted first with mem_we=1, then read granted. exec_rd_data=0o1234.
4. All three requests held continuously, STARVE_LIMIT=4 -> EXEC ops win 4 arbitrations, IFU is granted on the 5th, and starve_cnt returns to 0. There is never more than one gnt in a cycle.
5. RD_LATENCY=3, EXEC read of 0o4000 (value 0o0017) -> exec_rd_vld exactly 5 cycles after req with data 0o0017. No other gnt occurs during WAIT.
6. Back-to-back IFU reads of 0o0000..0o0007 with req held high -> 8 gnt/vld pairs in address order, each data equal to the memory contents. No vld is lost or duplicated.
